mult_acc_pipe: RTL and testbench
================================

MULT_ACC_PIPE -- requirements
Module: mult_acc_pipe

Interface
REQ-001 SHALL have parameter A_WIDTH, default 18, width of operand A (2..32).
REQ-002 SHALL have parameter B_WIDTH, default 18, width of operand B (2..32).
REQ-003 SHALL have parameter ACC_WIDTH, default 48, width of accumulator/result; elaboration error if < A_WIDTH+B_WIDTH.
REQ-004 SHALL have parameter LATENCY, default 2, CE-qualified edges from operand capture to P (1..4); elaboration error outside range.
REQ-005 SHALL have port C  input  1  clock, all state on rising edge.
REQ-006 SHALL have port R  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port CE  input  1  clock enable; 0 freezes all non-reset state.
REQ-008 SHALL have port IN_VALID  input  1  A/B/TC/ACC_EN qualify this edge.
REQ-009 SHALL have port A  input  A_WIDTH  multiplicand.
REQ-010 SHALL have port B  input  B_WIDTH  multiplier.
REQ-011 SHALL have port TC  input  1  1 = both operands two's complement, 0 = both unsigned.
REQ-012 SHALL have port ACC_EN  input  1  1 = add product to accumulator, 0 = load product.
REQ-013 SHALL have port P  output  ACC_WIDTH  registered accumulator/result.
REQ-014 SHALL have port OUT_VALID  output  1  P updated on the last edge.
REQ-015 SHALL have port OVF  output  1  sticky accumulation overflow flag.

Function
REQ-016 SHALL extend A and B per TC (sign- or zero-extend) to ACC_WIDTH and form the exact full product, truncated only to ACC_WIDTH.
REQ-017 SHALL carry A/B/TC/ACC_EN/IN_VALID through a pipeline of LATENCY register stages; the final stage is the accumulator register driving P.
REQ-018 SHALL advance every pipeline stage only on edges with CE=1; CE=0 holds all stages, P, OUT_VALID, OVF.
REQ-019 SHALL, on a CE=1 edge where final-stage valid is 1 and ACC_EN=0, load P with the extended product and clear OVF.
REQ-020 SHALL, on a CE=1 edge where final-stage valid is 1 and ACC_EN=1, set P = P + product modulo 2^ACC_WIDTH.
REQ-021 SHALL, on a CE=1 edge where final-stage valid is 0 (bubble), hold P and OVF.
REQ-022 SHALL set OVF on an accumulate whose true result is outside ACC_WIDTH range: signed range if the accumulating item has TC=1, unsigned (carry out) if TC=0; OVF stays set until a load or reset.
REQ-023 SHALL drive OUT_VALID = 1 for exactly the CE=1 edges that update P from a valid item; 0 after bubble edges; held when CE=0.
REQ-024 SHALL keep each item's TC and ACC_EN paired with its own operands; mixed-mode back-to-back items SHALL not interfere.
REQ-025 SHALL accept one item per CE=1 edge (full throughput, no backpressure).

Reset
REQ-026 SHALL, on any rising C with R=1, clear P, OVF, OUT_VALID and every pipeline valid bit to 0, regardless of CE.
REQ-027 SHALL discard in-flight items on reset; items presented on the reset edge SHALL be ignored.
REQ-028 SHALL resume normal operation on the first edge with R=0; the first valid item after reset SHALL accumulate onto P=0 if ACC_EN=1.

Verification
REQ-029 Reset: R=1 one edge, CE=0 -> P=0, OUT_VALID=0, OVF=0.
REQ-030 Signed: TC=1, ACC_EN=0, A=18'h3ff82, B=18'h04000 -> after LATENCY CE edges P=48'hFFFF_FFE0_8000, OUT_VALID=1; same with TC=0 -> P=48'h0000_FFE0_8000.
REQ-031 Accumulate: load 100*200 then two ACC_EN=1 items 100*200, TC=1 -> P=48'h0000_0000_EA60; a bubble edge afterwards -> P unchanged, OUT_VALID=0.
REQ-032 Overflow: ACC_WIDTH=36, TC=1, load 18'h20000*18'h20000 then accumulate same -> P=36'h8_0000_0000, OVF=1; subsequent load 1*1 -> P=1, OVF=0.
REQ-033 Stall and LATENCY sweep: LATENCY 1..4, 1000 random items, CE randomly deasserted -> P matches reference model per item, no item lost or duplicated.
REQ-034 Mid-flight reset: R=1 while LATENCY-1 items in flight -> no OUT_VALID pulse from those items, P=0 afterwards.

Source files
------------

// File: rtl/mult_acc_pipe.sv
// Pipelined multiply-accumulate: signed/unsigned product carried through LATENCY-1
// stages into an accumulator register with a sticky overflow flag.
module mult_acc_pipe #(
   parameter int A_WIDTH   = 18,
   parameter int B_WIDTH   = 18,
   parameter int ACC_WIDTH = 48,
   parameter int LATENCY   = 2
) (
   input  logic                 C,
   input  logic                 R,
   input  logic                 CE,
   input  logic                 IN_VALID,
   input  logic [A_WIDTH-1:0]   A,
   input  logic [B_WIDTH-1:0]   B,
   input  logic                 TC,
   input  logic                 ACC_EN,
   output logic [ACC_WIDTH-1:0] P,
   output logic                 OUT_VALID,
   output logic                 OVF
);

   if (A_WIDTH < 2 || A_WIDTH > 32) begin : g_bad_a_width
      $error("mult_acc_pipe: A_WIDTH must be in 2..32");
   end
   if (B_WIDTH < 2 || B_WIDTH > 32) begin : g_bad_b_width
      $error("mult_acc_pipe: B_WIDTH must be in 2..32");
   end
   if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_acc_width
      $error("mult_acc_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
   end
   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("mult_acc_pipe: LATENCY must be in 1..4");
   end

   logic [ACC_WIDTH-1:0] a_ext;
   logic [ACC_WIDTH-1:0] b_ext;
   logic [ACC_WIDTH-1:0] prod_in;

   // Extending both operands to ACC_WIDTH makes the modular product exact for either mode.
   always_comb begin
      a_ext   = {{(ACC_WIDTH-A_WIDTH){TC & A[A_WIDTH-1]}}, A};
      b_ext   = {{(ACC_WIDTH-B_WIDTH){TC & B[B_WIDTH-1]}}, B};
      prod_in = a_ext * b_ext;
   end

   logic                 fin_valid;
   logic                 fin_tc;
   logic                 fin_acc_en;
   logic [ACC_WIDTH-1:0] fin_prod;

   if (LATENCY == 1) begin : g_direct
      assign fin_valid  = IN_VALID;
      assign fin_tc     = TC;
      assign fin_acc_en = ACC_EN;
      assign fin_prod   = prod_in;
   end else begin : g_pipe
      localparam int DEPTH = LATENCY - 1;

      logic [ACC_WIDTH-1:0] prod_d [DEPTH];
      logic [ACC_WIDTH-1:0] prod_q [DEPTH];
      logic [DEPTH-1:0]     valid_d, valid_q;
      logic [DEPTH-1:0]     tc_d, tc_q;
      logic [DEPTH-1:0]     acc_en_d, acc_en_q;

      always_comb begin
         prod_d   = prod_q;
         valid_d  = valid_q;
         tc_d     = tc_q;
         acc_en_d = acc_en_q;
         if (CE) begin
            prod_d[0]   = prod_in;
            valid_d[0]  = IN_VALID;
            tc_d[0]     = TC;
            acc_en_d[0] = ACC_EN;
            for (int i = 1; i < DEPTH; i++) begin
               prod_d[i]   = prod_q[i-1];
               valid_d[i]  = valid_q[i-1];
               tc_d[i]     = tc_q[i-1];
               acc_en_d[i] = acc_en_q[i-1];
            end
         end
      end

      always_ff @(posedge C) begin
         if (R) begin
            valid_q <= '0;
         end else begin
            valid_q <= valid_d;
         end
         prod_q   <= prod_d;
         tc_q     <= tc_d;
         acc_en_q <= acc_en_d;
      end

      assign fin_valid  = valid_q[DEPTH-1];
      assign fin_tc     = tc_q[DEPTH-1];
      assign fin_acc_en = acc_en_q[DEPTH-1];
      assign fin_prod   = prod_q[DEPTH-1];
   end

   logic [ACC_WIDTH-1:0] p_d, p_q;
   logic                 ovf_d, ovf_q;
   logic                 out_valid_d, out_valid_q;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry_ovf;
   logic                 signed_ovf;

   always_comb begin
      sum        = {1'b0, p_q} + {1'b0, fin_prod};
      carry_ovf  = sum[ACC_WIDTH];
      // Signed overflow: like-signed addends producing a result of the opposite sign.
      signed_ovf = (p_q[ACC_WIDTH-1] == fin_prod[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != p_q[ACC_WIDTH-1]);
      p_d         = p_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      if (CE) begin
         out_valid_d = fin_valid;
         if (fin_valid) begin
            if (fin_acc_en) begin
               p_d   = sum[ACC_WIDTH-1:0];
               ovf_d = ovf_q | (fin_tc ? signed_ovf : carry_ovf);
            end else begin
               p_d   = fin_prod;
               ovf_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge C) begin
      if (R) begin
         p_q         <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         p_q         <= p_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign P         = p_q;
   assign OUT_VALID = out_valid_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Bench for mult_acc_pipe: four 48-bit instances (LATENCY 1..4) and one 36-bit instance
// share stimulus; a per-item arithmetic reference feeds a scoreboard read by a monitor.
module tb_mult_acc_pipe;

   logic        clk = 1'b0;
   logic        r, ce, iv, tc, acc_en;
   logic [17:0] a, b;

   logic [47:0] p_o [4];
   logic [35:0] p36;
   logic        ov_o [5];
   logic        ovf_o [5];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      mult_acc_pipe #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(48), .LATENCY(g + 1)) u_dut (
         .C(clk), .R(r), .CE(ce), .IN_VALID(iv), .A(a), .B(b), .TC(tc), .ACC_EN(acc_en),
         .P(p_o[g]), .OUT_VALID(ov_o[g]), .OVF(ovf_o[g]));
   end

   mult_acc_pipe #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(36), .LATENCY(2)) u_dut36 (
      .C(clk), .R(r), .CE(ce), .IN_VALID(iv), .A(a), .B(b), .TC(tc), .ACC_EN(acc_en),
      .P(p36), .OUT_VALID(ov_o[4]), .OVF(ovf_o[4]));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      longint p48;
      bit     o48;
      longint p36;
      bit     o36;
   } exp_t;

   exp_t   exp_q[$];
   int     rd[5];
   longint acc48, acc36;
   bit     ovf48, ovf36;

   function automatic longint sxt(input longint v, input int w);
      longint one = 1;
      return (v >= (one <<< (w - 1))) ? v - (one <<< w) : v;
   endfunction

   task automatic acc_step(input longint acc, input bit ovf, input longint prod, input bit t,
                           input bit e, input int w, output longint nacc, output bit novf);
      longint one = 1;
      longint mask, pm, tv, lo, hi;
      mask = (one <<< w) - 1;
      pm   = prod & mask;
      if (!e) begin
         nacc = pm;
         novf = 1'b0;
      end else begin
         tv   = (t ? sxt(acc, w) : acc) + (t ? sxt(pm, w) : pm);
         lo   = t ? -(one <<< (w - 1)) : 0;
         hi   = t ? (one <<< (w - 1)) - 1 : mask;
         novf = ovf | (tv < lo || tv > hi);
         nacc = tv & mask;
      end
   endtask

   task automatic model_push(input logic [17:0] aa, input logic [17:0] bb, input bit t, input bit e);
      longint av, bv, prod, n;
      bit     o;
      exp_t   x;
      av   = t ? sxt(longint'(aa), 18) : longint'(aa);
      bv   = t ? sxt(longint'(bb), 18) : longint'(bb);
      prod = av * bv;
      acc_step(acc48, ovf48, prod, t, e, 48, n, o);
      acc48 = n; ovf48 = o;
      acc_step(acc36, ovf36, prod, t, e, 36, n, o);
      acc36 = n; ovf36 = o;
      x.p48 = acc48; x.o48 = ovf48; x.p36 = acc36; x.o36 = ovf36;
      exp_q.push_back(x);
   endtask

   // ---------------- monitor ----------------
   logic ce_s = 1'b0;
   always @(posedge clk) ce_s <= ce;

   always @(negedge clk) begin
      if (ce_s) begin
         for (int k = 0; k < 5; k++) begin
            if (ov_o[k] === 1'b1) begin
               if (rd[k] >= exp_q.size()) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_out dut%0d: got OUT_VALID=1 expected no pending item", k);
               end else begin
                  exp_t e;
                  e = exp_q[rd[k]];
                  rd[k]++;
                  if (k < 4) begin
                     check($sformatf("sb_p dut%0d item%0d", k, rd[k]), {16'b0, p_o[k]}, e.p48);
                     check($sformatf("sb_ovf dut%0d item%0d", k, rd[k]), {63'b0, ovf_o[k]}, {63'b0, e.o48});
                  end else begin
                     check($sformatf("sb_p36 item%0d", rd[k]), {28'b0, p36}, e.p36);
                     check($sformatf("sb_ovf36 item%0d", rd[k]), {63'b0, ovf_o[k]}, {63'b0, e.o36});
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input bit v, input logic [17:0] aa, input logic [17:0] bb,
                        input bit t, input bit e, input bit c);
      r = 1'b0; iv = v; a = aa; b = bb; tc = t; acc_en = e; ce = c;
      if (c && v) model_push(aa, bb, t, e);
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      issue(1'b0, 18'h0, 18'h0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset(input bit c);
      r = 1'b1; ce = c; iv = 1'b1; a = 18'($urandom()); b = 18'($urandom());
      tc = 1'b1; acc_en = 1'b1;
      @(posedge clk);
      #1;
      r = 1'b0; iv = 1'b0;
      acc48 = 0; acc36 = 0; ovf48 = 1'b0; ovf36 = 1'b0;
      for (int k = 0; k < 5; k++) rd[k] = exp_q.size();
   endtask

   task automatic lat_check(input int n);
      for (int k = 0; k < 5; k++) begin
         int lat;
         lat = (k < 4) ? k + 1 : 2;
         check($sformatf("latency edge%0d dut%0d", n, k), {63'b0, ov_o[k]}, {63'b0, (n == lat)});
      end
   endtask

   function automatic logic [17:0] pick();
      case ($urandom_range(0, 4))
         0:       return 18'h20000;
         1:       return 18'h1ffff;
         2:       return 18'h3ffff;
         default: return 18'($urandom());
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int accepted;
      r = 1'b0; ce = 1'b0; iv = 1'b0; a = '0; b = '0; tc = 1'b0; acc_en = 1'b0;
      acc48 = 0; acc36 = 0; ovf48 = 1'b0; ovf36 = 1'b0;
      for (int k = 0; k < 5; k++) rd[k] = 0;

      // Reset with CE low still clears everything
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("reset_p dut%0d", k), {16'b0, p_o[k]}, 64'd0);
         check($sformatf("reset_ov dut%0d", k), {63'b0, ov_o[k]}, 64'd0);
         check($sformatf("reset_ovf dut%0d", k), {63'b0, ovf_o[k]}, 64'd0);
      end
      check("reset_p36", {28'b0, p36}, 64'd0);

      // Signed load and latency per instance
      issue(1'b1, 18'h3ff82, 18'h04000, 1'b1, 1'b0, 1'b1);
      lat_check(1);
      for (int n = 2; n <= 5; n++) begin
         bubble();
         lat_check(n);
         if (n == 2) check("signed_load_p", {16'b0, p_o[1]}, 64'h0000_FFFF_FFE0_8000);
      end

      // Same operands unsigned
      issue(1'b1, 18'h3ff82, 18'h04000, 1'b0, 1'b0, 1'b1);
      bubble();
      check("unsigned_load_p", {16'b0, p_o[1]}, 64'h0000_0000_FFE0_8000);
      check("unsigned_load_ov", {63'b0, ov_o[1]}, 64'd1);
      repeat (4) bubble();

      // Load then two accumulates, then a bubble
      issue(1'b1, 18'd100, 18'd200, 1'b1, 1'b0, 1'b1);
      issue(1'b1, 18'd100, 18'd200, 1'b1, 1'b1, 1'b1);
      issue(1'b1, 18'd100, 18'd200, 1'b1, 1'b1, 1'b1);
      bubble();
      check("accum_p", {16'b0, p_o[1]}, 64'h0000_0000_0000_EA60);
      check("accum_ov", {63'b0, ov_o[1]}, 64'd1);
      bubble();
      check("bubble_p", {16'b0, p_o[1]}, 64'h0000_0000_0000_EA60);
      check("bubble_ov", {63'b0, ov_o[1]}, 64'd0);
      repeat (3) bubble();

      // Signed overflow on the 36-bit instance, cleared by a load
      issue(1'b1, 18'h20000, 18'h20000, 1'b1, 1'b0, 1'b1);
      issue(1'b1, 18'h20000, 18'h20000, 1'b1, 1'b1, 1'b1);
      bubble();
      check("ovf36_p", {28'b0, p36}, 64'h8_0000_0000);
      check("ovf36_flag", {63'b0, ovf_o[4]}, 64'd1);
      issue(1'b1, 18'd1, 18'd1, 1'b1, 1'b0, 1'b1);
      bubble();
      check("reload36_p", {28'b0, p36}, 64'd1);
      check("reload36_flag", {63'b0, ovf_o[4]}, 64'd0);
      repeat (3) bubble();

      // Reset with three items in flight in the LATENCY=4 instance
      issue(1'b1, 18'd7, 18'd9, 1'b0, 1'b0, 1'b1);
      issue(1'b1, 18'd5, 18'd3, 1'b0, 1'b1, 1'b1);
      issue(1'b1, 18'd2, 18'd4, 1'b0, 1'b1, 1'b1);
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) check($sformatf("midreset_p dut%0d", k), {16'b0, p_o[k]}, 64'd0);
      for (int n = 0; n < 5; n++) begin
         bubble();
         check($sformatf("midreset_ov cyc%0d", n), {63'b0, ov_o[3]}, 64'd0);
         check($sformatf("midreset_p4 cyc%0d", n), {16'b0, p_o[3]}, 64'd0);
      end

      // Random items with random stalls and bubbles
      accepted = 0;
      while (accepted < 1000) begin
         bit v, c;
         v = ($urandom_range(0, 9) < 8);
         c = ($urandom_range(0, 3) != 0);
         issue(v, pick(), pick(), 1'($urandom()), ($urandom_range(0, 9) < 7), c);
         if (v && c) accepted++;
      end
      repeat (6) bubble();

      for (int k = 0; k < 5; k++)
         check($sformatf("items_consumed dut%0d", k), 64'(rd[k]), 64'(exp_q.size()));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
